// File: rtl/spi_master_interface.sv
// SPI mode 0 master (CPOL=0, CPHA=0), MSB first, one word per chip-select frame.
// The host starts a frame with start and sees busy, then a one-cycle done pulse.
//
// state    | meaning
// ST_IDLE  | cs high, waiting for start
// ST_SETUP | cs low, sck low, cs-to-first-edge setup time
// ST_SHIFT | sck toggles every CLK_DIV clk; sample on rise, shift on fall
// ST_HOLD  | sck low after the last fall, cs still low
// ST_GAP   | cs high, minimum idle time before the next frame
module spi_master_interface #(
  parameter int DATA_WIDTH      = 16,
  parameter int CLK_DIV         = 4,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_IDLE_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int HALF_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int TMAX_A = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int TMAX   = (TMAX_A > CS_IDLE_CYCLES) ? TMAX_A : CS_IDLE_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t                state, state_nxt;
  logic [HALF_W-1:0]     half_cnt, half_cnt_nxt;
  logic [TMR_W-1:0]      tmr, tmr_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  // MSB goes straight to mosi on accept, so only the remaining bits are kept here
  logic [DATA_WIDTH-2:0] tx_shift, tx_shift_nxt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_WIDTH-1:0] data_received_nxt;
  logic                  cs_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      half_cnt      <= '0;
      tmr           <= '0;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      data_received <= '0;
      cs            <= 1'b1;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      half_cnt      <= half_cnt_nxt;
      tmr           <= tmr_nxt;
      bit_cnt       <= bit_cnt_nxt;
      tx_shift      <= tx_shift_nxt;
      rx_shift      <= rx_shift_nxt;
      data_received <= data_received_nxt;
      cs            <= cs_nxt;
      sck           <= sck_nxt;
      mosi          <= mosi_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    half_cnt_nxt      = half_cnt;
    tmr_nxt           = tmr;
    bit_cnt_nxt       = bit_cnt;
    tx_shift_nxt      = tx_shift;
    rx_shift_nxt      = rx_shift;
    data_received_nxt = data_received;
    cs_nxt            = cs;
    sck_nxt           = sck;
    mosi_nxt          = mosi;
    busy_nxt          = busy;
    done_nxt          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          tx_shift_nxt = data_to_send[DATA_WIDTH-2:0];
          mosi_nxt     = data_to_send[DATA_WIDTH-1];
          cs_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          bit_cnt_nxt  = '0;
          tmr_nxt      = TMR_W'(CS_SETUP_CYCLES - 1);
          state_nxt    = ST_SETUP;
        end else begin
          mosi_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tmr == '0) begin
          half_cnt_nxt = '0;
          state_nxt    = ST_SHIFT;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (half_cnt == HALF_W'(CLK_DIV - 1)) begin
          half_cnt_nxt = '0;
          sck_nxt      = ~sck;
          if (!sck) begin
            rx_shift_nxt = {rx_shift[DATA_WIDTH-2:0], miso};
          end else if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            tmr_nxt   = TMR_W'(CS_HOLD_CYCLES - 1);
            state_nxt = ST_HOLD;
          end else begin
            bit_cnt_nxt  = bit_cnt + 1'b1;
            mosi_nxt     = tx_shift[DATA_WIDTH-2];
            tx_shift_nxt = {tx_shift[DATA_WIDTH-3:0], 1'b0};
          end
        end else begin
          half_cnt_nxt = half_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr == '0) begin
          cs_nxt            = 1'b1;
          data_received_nxt = rx_shift;
          done_nxt          = 1'b1;
          tmr_nxt           = TMR_W'(CS_IDLE_CYCLES - 1);
          state_nxt         = ST_GAP;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr == '0) begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
